// File: rtl/reg_file_sb_pkg.sv
// Shared types and constants for the register file with pending scoreboard.
package reg_file_sb_pkg;

  // Default geometry: 16 registers of 8 bits.
  localparam int DEF_W = 8;
  localparam int DEF_A = 4;

  // Index of the register that may be hard-wired to zero.
  localparam int ZERO_REG = 0;

  typedef logic [DEF_A-1:0] addr_t;
  typedef logic [DEF_W-1:0] data_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-result scoreboard: one bit per register set on issue, cleared on
// write-back, with an incrementally maintained count of pending registers.
module reg_file_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int A       = DEF_A,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_ena,
  input  logic [A-1:0] wr_addr,
  input  logic         iss_ena,
  input  logic [A-1:0] iss_rd,
  input  logic [A-1:0] rs,
  input  logic [A-1:0] rt,
  output logic         s_busy,
  output logic         t_busy,
  output logic [A:0]   busy_cnt,
  output logic         iss_conflict
);

  localparam int N = 1 << A;
  localparam logic [A-1:0] ZERO_ADDR = A'(ZERO_REG);

  logic [N-1:0] pending_reg;
  logic [N-1:0] pending_next;
  logic [A:0]   busy_cnt_reg;

  logic wr_eff;
  logic iss_eff;
  logic set_inc;
  logic clr_dec;

  // Writes and issues to the hard-wired zero register are ignored.
  assign wr_eff  = wr_ena  & ~(R0_ZERO && (wr_addr == ZERO_ADDR));
  assign iss_eff = iss_ena & ~(R0_ZERO && (iss_rd  == ZERO_ADDR));

  // A set only counts if the bit was clear; a clear only counts if the bit
  // was set and is not simultaneously re-set by an issue to the same address.
  assign set_inc = iss_eff & ~pending_reg[iss_rd];
  assign clr_dec = wr_eff & pending_reg[wr_addr] & ~(iss_eff && (iss_rd == wr_addr));

  // Next pending vector: write-back clears, issue sets afterwards so it wins.
  always_comb begin
    pending_next = pending_reg;
    if (wr_eff)  pending_next[wr_addr] = 1'b0;
    if (iss_eff) pending_next[iss_rd]  = 1'b1;
  end

  // Pending bits and count, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_reg  <= '0;
      busy_cnt_reg <= '0;
    end else begin
      pending_reg  <= pending_next;
      busy_cnt_reg <= busy_cnt_reg + (A+1)'(set_inc) - (A+1)'(clr_dec);
    end
  end

  assign busy_cnt = busy_cnt_reg;

  // A register being written this cycle is resolved by the bypass path.
  assign s_busy = pending_reg[rs] & ~(wr_eff && (wr_addr == rs))
                & ~(R0_ZERO && (rs == ZERO_ADDR));
  assign t_busy = pending_reg[rt] & ~(wr_eff && (wr_addr == rt))
                & ~(R0_ZERO && (rt == ZERO_ADDR));

  // Advisory WAW flag: destination already pending and not being retired now.
  assign iss_conflict = iss_ena & pending_reg[iss_rd] & ~(wr_ena && (wr_addr == iss_rd));

endmodule

// File: rtl/reg_file_sb.sv
// Two-read / one-write register file with write-to-read bypass, optional
// hard-wired zero register, and a pending-result scoreboard for the issue stage.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int A       = DEF_A,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_ena,
  input  logic [A-1:0] wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic         iss_ena,
  input  logic [A-1:0] iss_rd,
  input  logic [A-1:0] rs,
  input  logic [A-1:0] rt,
  output logic [W-1:0] s,
  output logic [W-1:0] t,
  output logic         s_busy,
  output logic         t_busy,
  output logic [A:0]   busy_cnt,
  output logic         iss_conflict
);

  localparam int N = 1 << A;
  localparam logic [A-1:0] ZERO_ADDR = A'(ZERO_REG);

  logic [W-1:0] regs_reg [N];
  logic         wr_eff;
  logic         s_zero;
  logic         t_zero;
  logic         s_byp;
  logic         t_byp;

  assign wr_eff = wr_ena & ~(R0_ZERO && (wr_addr == ZERO_ADDR));
  assign s_zero = R0_ZERO && (rs == ZERO_ADDR);
  assign t_zero = R0_ZERO && (rt == ZERO_ADDR);
  assign s_byp  = wr_eff && (wr_addr == rs);
  assign t_byp  = wr_eff && (wr_addr == rt);

  // Storage array; async reset means it maps to flops rather than block RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) regs_reg[i] <= '0;
    end else if (wr_eff) begin
      regs_reg[wr_addr] <= wr_data;
    end
  end

  // Read ports: zero register, then same-cycle bypass, then stored value.
  always_comb begin
    s = regs_reg[rs];
    t = regs_reg[rt];
    if (s_byp)  s = wr_data;
    if (t_byp)  t = wr_data;
    if (s_zero) s = '0;
    if (t_zero) t = '0;
  end

  reg_file_scoreboard #(
    .A       (A),
    .R0_ZERO (R0_ZERO)
  ) u_sb (
    .clk          (clk),
    .reset        (reset),
    .wr_ena       (wr_ena),
    .wr_addr      (wr_addr),
    .iss_ena      (iss_ena),
    .iss_rd       (iss_rd),
    .rs           (rs),
    .rt           (rt),
    .s_busy       (s_busy),
    .t_busy       (t_busy),
    .busy_cnt     (busy_cnt),
    .iss_conflict (iss_conflict)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a zero-register instance (main) and an
// ordinary-register-0 instance (_b) driven by the same stimulus.
module tb_reg_file_sb;
  import reg_file_sb_pkg::*;

  logic  clk = 1'b0;
  logic  reset;
  logic  wr_ena;
  addr_t wr_addr;
  data_t wr_data;
  logic  iss_ena;
  addr_t iss_rd;
  addr_t rs;
  addr_t rt;

  data_t      s, t, s_b, t_b;
  logic       s_busy, t_busy, iss_conflict;
  logic       s_busy_b, t_busy_b, iss_conflict_b;
  logic [4:0] busy_cnt, busy_cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.W(8), .A(4), .R0_ZERO(1'b1)) dut (
    .clk(clk), .reset(reset), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_ena(iss_ena), .iss_rd(iss_rd), .rs(rs), .rt(rt), .s(s), .t(t),
    .s_busy(s_busy), .t_busy(t_busy), .busy_cnt(busy_cnt), .iss_conflict(iss_conflict)
  );

  reg_file_sb #(.W(8), .A(4), .R0_ZERO(1'b0)) dut_b (
    .clk(clk), .reset(reset), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_ena(iss_ena), .iss_rd(iss_rd), .rs(rs), .rt(rt), .s(s_b), .t(t_b),
    .s_busy(s_busy_b), .t_busy(t_busy_b), .busy_cnt(busy_cnt_b), .iss_conflict(iss_conflict_b)
  );

  // Advance to just after the next rising edge; inputs then settle for the cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_ena  = 1'b0;
    iss_ena = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_ena = 0; wr_addr = 0; wr_data = 0; iss_ena = 0; iss_rd = 0; rs = 3; rt = 4;
    #2;
    n_checks++; if (s !== 8'h00) begin n_fail++; $display("FAIL reset_s: got %h expected 00", s); end
    n_checks++; if (t !== 8'h00) begin n_fail++; $display("FAIL reset_t: got %h expected 00", t); end
    n_checks++; if (busy_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", busy_cnt); end
    n_checks++; if ({s_busy, t_busy, iss_conflict} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {s_busy, t_busy, iss_conflict}); end
    @(negedge clk);
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_bypass();
    step();
    wr_ena = 1; wr_addr = 3; wr_data = 8'h5A; rs = 3;
    #2;
    n_checks++; if (s !== 8'h5A) begin n_fail++; $display("FAIL bypass_s: got %h expected 5a", s); end
    n_checks++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL bypass_busy: got %b expected 0", s_busy); end
    step();
    idle();
    #2;
    n_checks++; if (s !== 8'h5A) begin n_fail++; $display("FAIL array_s: got %h expected 5a", s); end
    n_checks++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL array_busy: got %b expected 0", s_busy); end
    $display("test_bypass done");
  endtask

  task automatic test_r0();
    step();
    wr_ena = 1; wr_addr = 0; wr_data = 8'hFF; iss_ena = 1; iss_rd = 0; rs = 0;
    #2;
    n_checks++; if (s !== 8'h00) begin n_fail++; $display("FAIL r0_zero_s_byp: got %h expected 00", s); end
    n_checks++; if (s_b !== 8'hFF) begin n_fail++; $display("FAIL r0_plain_s_byp: got %h expected ff", s_b); end
    step();
    idle();
    #2;
    n_checks++; if (s !== 8'h00) begin n_fail++; $display("FAIL r0_zero_s: got %h expected 00", s); end
    n_checks++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL r0_zero_busy: got %b expected 0", s_busy); end
    n_checks++; if (busy_cnt !== 5'd0) begin n_fail++; $display("FAIL r0_zero_cnt: got %0d expected 0", busy_cnt); end
    n_checks++; if (s_b !== 8'hFF) begin n_fail++; $display("FAIL r0_plain_s: got %h expected ff", s_b); end
    n_checks++; if (busy_cnt_b !== 5'd1) begin n_fail++; $display("FAIL r0_plain_cnt: got %0d expected 1", busy_cnt_b); end
    $display("test_r0 done");
  endtask

  task automatic test_pending();
    step(); iss_ena = 1; iss_rd = 5;
    step(); iss_rd = 7;
    step(); idle(); rs = 5; rt = 7;
    #2;
    n_checks++; if (busy_cnt !== 5'd2) begin n_fail++; $display("FAIL pend_cnt2: got %0d expected 2", busy_cnt); end
    n_checks++; if ({s_busy, t_busy} !== 2'b11) begin n_fail++; $display("FAIL pend_busy: got %b expected 11", {s_busy, t_busy}); end
    step(); wr_ena = 1; wr_addr = 5; wr_data = 8'h11;
    #2;
    n_checks++; if (s !== 8'h11) begin n_fail++; $display("FAIL pend_byp_s: got %h expected 11", s); end
    n_checks++; if ({s_busy, t_busy} !== 2'b01) begin n_fail++; $display("FAIL pend_byp_busy: got %b expected 01", {s_busy, t_busy}); end
    step(); idle();
    #2;
    n_checks++; if (busy_cnt !== 5'd1) begin n_fail++; $display("FAIL pend_cnt1: got %0d expected 1", busy_cnt); end
    n_checks++; if (s !== 8'h11) begin n_fail++; $display("FAIL pend_array_s: got %h expected 11", s); end
    $display("test_pending done");
  endtask

  // Pending afterwards: r7, r9.
  task automatic test_same_addr();
    step(); iss_ena = 1; iss_rd = 9;
    step(); idle(); rs = 9;
    #2;
    n_checks++; if (busy_cnt !== 5'd2) begin n_fail++; $display("FAIL same_cnt_pre: got %0d expected 2", busy_cnt); end
    step(); wr_ena = 1; wr_addr = 9; wr_data = 8'h99; iss_ena = 1; iss_rd = 9;
    #2;
    n_checks++; if (s !== 8'h99) begin n_fail++; $display("FAIL same_byp_s: got %h expected 99", s); end
    n_checks++; if (iss_conflict !== 1'b0) begin n_fail++; $display("FAIL same_conflict_wr: got %b expected 0", iss_conflict); end
    step(); idle();
    #2;
    n_checks++; if (busy_cnt !== 5'd2) begin n_fail++; $display("FAIL same_cnt: got %0d expected 2", busy_cnt); end
    n_checks++; if (s_busy !== 1'b1) begin n_fail++; $display("FAIL same_pending: got %b expected 1", s_busy); end
    n_checks++; if (s !== 8'h99) begin n_fail++; $display("FAIL same_data: got %h expected 99", s); end
    iss_ena = 1; iss_rd = 9;
    #1;
    n_checks++; if (iss_conflict !== 1'b1) begin n_fail++; $display("FAIL waw_conflict: got %b expected 1", iss_conflict); end
    step(); idle();
    #2;
    n_checks++; if (busy_cnt !== 5'd2) begin n_fail++; $display("FAIL waw_cnt: got %0d expected 2", busy_cnt); end
    $display("test_same_addr done");
  endtask

  // Pending afterwards: r4, r7, r9.
  task automatic test_diff_addr();
    step(); iss_ena = 1; iss_rd = 2;
    step(); idle();
    #2;
    n_checks++; if (busy_cnt !== 5'd3) begin n_fail++; $display("FAIL diff_cnt_pre: got %0d expected 3", busy_cnt); end
    step(); wr_ena = 1; wr_addr = 2; wr_data = 8'h22; iss_ena = 1; iss_rd = 4;
    step(); idle(); rs = 2; rt = 4;
    #2;
    n_checks++; if (busy_cnt !== 5'd3) begin n_fail++; $display("FAIL diff_cnt: got %0d expected 3", busy_cnt); end
    n_checks++; if ({s_busy, t_busy} !== 2'b01) begin n_fail++; $display("FAIL diff_busy: got %b expected 01", {s_busy, t_busy}); end
    n_checks++; if (s !== 8'h22) begin n_fail++; $display("FAIL diff_s: got %h expected 22", s); end
    $display("test_diff_addr done");
  endtask

  task automatic test_back_to_back();
    data_t exp_d [4];
    exp_d[0] = 8'hA1; exp_d[1] = 8'hB2; exp_d[2] = 8'hC3; exp_d[3] = 8'hD4;
    for (int i = 0; i < 4; i++) begin
      step(); wr_ena = 1; wr_addr = addr_t'(10 + i); wr_data = exp_d[i];
    end
    step(); idle();
    for (int i = 0; i < 4; i++) begin
      rs = addr_t'(10 + i); rt = addr_t'(13 - i);
      #1;
      n_checks++; if (s !== exp_d[i]) begin n_fail++; $display("FAIL b2b_s%0d: got %h expected %h", i, s, exp_d[i]); end
      n_checks++; if (t !== exp_d[3-i]) begin n_fail++; $display("FAIL b2b_t%0d: got %h expected %h", i, t, exp_d[3-i]); end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_fill_and_reset();
    for (int i = 0; i < 16; i++) begin
      step(); iss_ena = 1; iss_rd = addr_t'(i);
    end
    step(); idle();
    #2;
    n_checks++; if (busy_cnt !== 5'd15) begin n_fail++; $display("FAIL fill_cnt: got %0d expected 15", busy_cnt); end
    iss_ena = 1; iss_rd = 15;
    step(); idle();
    #2;
    n_checks++; if (busy_cnt !== 5'd15) begin n_fail++; $display("FAIL fill_nowrap: got %0d expected 15", busy_cnt); end
    rs = 5; rt = 6;
    #1;
    reset = 1'b1;
    #1;
    n_checks++; if (busy_cnt !== 5'd0) begin n_fail++; $display("FAIL areset_cnt: got %0d expected 0", busy_cnt); end
    n_checks++; if ({s, t} !== 16'h0000) begin n_fail++; $display("FAIL areset_st: got %h expected 0000", {s, t}); end
    n_checks++; if ({s_busy, t_busy} !== 2'b00) begin n_fail++; $display("FAIL areset_busy: got %b expected 00", {s_busy, t_busy}); end
    wr_ena = 1; wr_addr = 5; wr_data = 8'h77;
    #1;
    n_checks++; if (s !== 8'h77) begin n_fail++; $display("FAIL areset_byp: got %h expected 77", s); end
    @(negedge clk);
    idle();
    reset = 1'b0;
    $display("test_fill_and_reset done");
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_r0();
    test_pending();
    test_same_addr();
    test_diff_addr();
    test_back_to_back();
    test_fill_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
